// File: rtl/pos_cell_mem_ctrl_if.sv
// Single-port cell position RAM bus: controller drives address/data/enables, RAM returns q
// two cycles after a sampled rden.
interface pos_cell_mem_ctrl_if #(
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_rden;
  logic                  mem_wren;
  logic [DATA_WIDTH-1:0] mem_q;

  modport master (
    output mem_address, mem_data, mem_rden, mem_wren,
    input  mem_q
  );

  modport slave (
    input  mem_address, mem_data, mem_rden, mem_wren,
    output mem_q
  );
endinterface

// File: rtl/pos_cell_mem_ctrl.sv
// Sweeps one cell position RAM (count word at addr 0, then particles 1..count) to the force
// pipeline, yielding the single RAM port to motion-update writes whenever they request it.
//
// state      | meaning
// S_IDLE     | waiting for i_rd_start
// S_CNT_ISS  | issue count-word read (addr 0) on the first free port cycle
// S_CNT_WAIT | wait for the tagged count return, latch and clamp it
// S_STREAM   | issue particle reads 1..count, one per free port cycle
// S_DRAIN    | wait for in-flight reads to return, then pulse o_rd_done
module pos_cell_mem_ctrl #(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_rd_start,
  input  logic                  i_wr_valid,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_wr_ready,
  pos_cell_mem_ctrl_if.master   mem,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic [ADDR_WIDTH-1:0] o_rd_pid,
  output logic                  o_rd_valid,
  output logic                  o_rd_done,
  output logic                  o_busy,
  output logic                  o_cnt_err
);
  localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

  typedef enum logic [2:0] {S_IDLE, S_CNT_ISS, S_CNT_WAIT, S_STREAM, S_DRAIN} state_t;
  state_t r_state, w_state_nxt;

  logic                  r_wr_ready, r_mem_rden, r_mem_wren, r_p0_cnt;
  logic [ADDR_WIDTH-1:0] r_mem_address;
  logic [DATA_WIDTH-1:0] r_mem_data;
  logic                  r_p1_vld, r_p1_cnt, r_p2_vld, r_p2_cnt;
  logic [ADDR_WIDTH-1:0] r_p1_addr, r_p2_addr;
  logic [ADDR_WIDTH-1:0] r_count, r_iss;
  logic                  r_cnt_err;

  logic                  w_wr_acc, w_port_free, w_cnt_ret, w_cnt_ovf, w_pipe_empty;
  logic [ADDR_WIDTH-1:0] w_cnt_raw;
  logic                  w_iss_rd, w_iss_cnt, w_rd_done, w_rd_valid;
  logic [ADDR_WIDTH-1:0] w_iss_addr;

  assign w_wr_acc     = i_wr_valid & r_wr_ready;
  assign w_port_free  = ~w_wr_acc;
  assign w_cnt_ret    = r_p2_vld & r_p2_cnt;
  assign w_cnt_raw    = mem.mem_q[ADDR_WIDTH-1:0];
  assign w_cnt_ovf    = w_cnt_raw > MAX_CNT;
  assign w_pipe_empty = ~r_mem_rden & ~r_p1_vld & ~r_p2_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (i_rd_start) w_state_nxt = S_CNT_ISS;
      S_CNT_ISS:  if (w_port_free) w_state_nxt = S_CNT_WAIT;
      S_CNT_WAIT: if (w_cnt_ret) w_state_nxt = (w_cnt_raw == '0) ? S_DRAIN : S_STREAM;
      S_STREAM:   if (w_port_free && (r_iss == r_count)) w_state_nxt = S_DRAIN;
      S_DRAIN:    if (w_pipe_empty) w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_iss_rd   = 1'b0;
    w_iss_cnt  = 1'b0;
    w_iss_addr = '0;
    w_rd_done  = 1'b0;
    case (r_state)
      S_CNT_ISS: begin
        w_iss_rd  = w_port_free;
        w_iss_cnt = 1'b1;
      end
      S_STREAM: begin
        w_iss_rd   = w_port_free;
        w_iss_addr = r_iss;
      end
      S_DRAIN:   w_rd_done = w_pipe_empty;
      default: ;
    endcase
  end

  // Port mux is registered so wr_valid never reaches the RAM pins combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ready    <= 1'b0;
      r_mem_rden    <= 1'b0;
      r_mem_wren    <= 1'b0;
      r_mem_address <= '0;
      r_mem_data    <= '0;
      r_p0_cnt      <= 1'b0;
      r_p1_vld      <= 1'b0;
      r_p1_cnt      <= 1'b0;
      r_p1_addr     <= '0;
      r_p2_vld      <= 1'b0;
      r_p2_cnt      <= 1'b0;
      r_p2_addr     <= '0;
      r_count       <= '0;
      r_iss         <= ADDR_WIDTH'(1);
      r_cnt_err     <= 1'b0;
    end else begin
      r_wr_ready    <= 1'b1;
      r_mem_wren    <= w_wr_acc;
      r_mem_rden    <= w_iss_rd;
      r_p0_cnt      <= w_iss_rd & w_iss_cnt;
      r_mem_address <= w_wr_acc ? i_wr_addr : (w_iss_rd ? w_iss_addr : '0);
      r_mem_data    <= w_wr_acc ? i_wr_data : '0;
      r_p1_vld      <= r_mem_rden;
      r_p1_cnt      <= r_p0_cnt;
      r_p1_addr     <= r_mem_address;
      r_p2_vld      <= r_p1_vld;
      r_p2_cnt      <= r_p1_cnt;
      r_p2_addr     <= r_p1_addr;
      if (r_state == S_CNT_WAIT && w_cnt_ret) begin
        r_count <= w_cnt_ovf ? MAX_CNT : w_cnt_raw;
        r_iss   <= ADDR_WIDTH'(1);
        if (w_cnt_ovf) r_cnt_err <= 1'b1;
      end else if (r_state == S_STREAM && w_port_free && r_iss != r_count) begin
        r_iss <= r_iss + 1'b1;
      end
    end
  end

  assign w_rd_valid      = r_p2_vld & ~r_p2_cnt;
  assign o_rd_valid      = w_rd_valid;
  assign o_rd_data       = w_rd_valid ? mem.mem_q : '0;
  assign o_rd_pid        = w_rd_valid ? r_p2_addr : '0;
  assign o_rd_done       = w_rd_done;
  assign o_busy          = (r_state != S_IDLE);
  assign o_cnt_err       = r_cnt_err;
  assign o_wr_ready      = r_wr_ready;
  assign mem.mem_rden    = r_mem_rden;
  assign mem.mem_wren    = r_mem_wren;
  assign mem.mem_address = r_mem_address;
  assign mem.mem_data    = r_mem_data;
endmodule

// File: tb/tb_pos_cell_mem_ctrl.sv
// Directed + randomized bench for pos_cell_mem_ctrl: a 2-cycle RAM model and a reference
// array of what each particle word should hold; streams are compared against it.
module tb_pos_cell_mem_ctrl;
  localparam int DW = 96;
  localparam int AW = 8;
  localparam int PN = 220;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_rd_start, i_wr_valid;
  logic [AW-1:0] i_wr_addr;
  logic [DW-1:0] i_wr_data;
  logic          o_wr_ready, o_rd_valid, o_rd_done, o_busy, o_cnt_err;
  logic [DW-1:0] o_rd_data;
  logic [AW-1:0] o_rd_pid;

  pos_cell_mem_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mif ();

  pos_cell_mem_ctrl #(.DATA_WIDTH(DW), .PARTICLE_NUM(PN), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .i_rd_start(i_rd_start), .i_wr_valid(i_wr_valid),
    .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .o_wr_ready(o_wr_ready), .mem(mif),
    .o_rd_data(o_rd_data), .o_rd_pid(o_rd_pid), .o_rd_valid(o_rd_valid),
    .o_rd_done(o_rd_done), .o_busy(o_busy), .o_cnt_err(o_cnt_err));

  always #5 clk = ~clk;

  // RAM model: address sampled at one edge, q registered at the next.
  logic [DW-1:0] ram [0:255];
  logic [AW-1:0] ram_a1;
  logic [DW-1:0] ram_q;
  always @(posedge clk) begin
    if (mif.mem_wren) ram[mif.mem_address] <= mif.mem_data;
    ram_a1 <= mif.mem_address;
    ram_q  <= ram[ram_a1];
  end
  assign mif.mem_q = ram_q;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0] got_pid[$];
  logic [DW-1:0] got_data[$];
  int            got_cyc[$];
  int            done_n = 0, addr0_n = 0, conflict_n = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_rd_valid) begin
        got_pid.push_back(o_rd_pid);
        got_data.push_back(o_rd_data);
        got_cyc.push_back(cyc);
      end
      if (o_rd_done) done_n <= done_n + 1;
      if (mif.mem_rden && mif.mem_address == '0) addr0_n <= addr0_n + 1;
      if (mif.mem_rden && mif.mem_wren) conflict_n <= conflict_n + 1;
    end
  end

  int            total = 0, bad = 0;
  logic [DW-1:0] ref_mem [0:255];
  bit            err_exp = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    i_wr_valid = 1'b1; i_wr_addr = a; i_wr_data = d;
    ref_mem[a] = d;
    @(negedge clk);
    i_wr_valid = 1'b0;
  endtask

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  // Count word carries random upper bits; only its low AW bits are the count.
  task automatic load(input int cw, input int n);
    logic [DW-1:0] w;
    w = rnd_word();
    w[AW-1:0] = AW'(cw);
    wr('0, w);
    for (int k = 1; k <= n; k++) wr(AW'(k), rnd_word());
  endtask

  task automatic pulse_start(output int sc);
    i_rd_start = 1'b1;
    @(negedge clk);
    sc = cyc;
    i_rd_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd, input int lim, input int p0,
                           input int restart_at, output int done_at, output bit ok);
    logic [AW-1:0] a;
    ok = 1'b0; done_at = 0;
    for (int i = 0; i < budget; i++) begin
      if (o_rd_done) begin ok = 1'b1; done_at = cyc; break; end
      i_rd_start = (i == restart_at);
      i_wr_valid = 1'b0;
      if (rnd && $urandom_range(3) == 0) begin
        if (got_pid.size() > p0 && $urandom_range(1) == 0) a = '0;
        else a = AW'($urandom_range(PN - 1, lim + 1));
        i_wr_valid = 1'b1; i_wr_addr = a; i_wr_data = rnd_word();
        ref_mem[a] = i_wr_data;
      end
      @(negedge clk);
    end
    i_wr_valid = 1'b0; i_rd_start = 1'b0;
  endtask

  task automatic check_stream(input string tag, input int p0, input int n_exp);
    int b0;
    chk({tag, " pulses"}, got_pid.size() - p0, n_exp);
    b0 = bad;
    for (int i = 0; i < n_exp && p0 + i < got_pid.size(); i++) begin
      chk({tag, " pid"}, got_pid[p0 + i], i + 1);
      chk({tag, " data"}, got_data[p0 + i], ref_mem[i + 1]);
      if (bad != b0) break;
    end
  endtask

  task automatic after_done(input string tag);
    @(negedge clk);
    chk({tag, " busy low"}, o_busy, 1'b0);
    chk({tag, " done 1 cycle"}, o_rd_done, 1'b0);
  endtask

  initial begin
    int sc, done_at, p0, d0, a0, cw, span;
    bit ok, found;
    rst_n = 1'b0; i_rd_start = 1'b0; i_wr_valid = 1'b0; i_wr_addr = '0; i_wr_data = '0;
    #3;
    chk("reset outputs",
        {o_wr_ready, o_rd_valid, o_rd_done, o_busy, o_cnt_err, o_rd_pid, mif.mem_rden,
         mif.mem_wren, mif.mem_address}, '0);
    chk("reset data", {o_rd_data, mif.mem_data}, '0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("wr_ready after reset", o_wr_ready, 1'b1);

    // count=5, no writes: 5 consecutive pulses, done one cycle after the last
    load(5, 5);
    p0 = got_pid.size();
    pulse_start(sc);
    wait_done(100, 1'b0, 5, p0, -1, done_at, ok);
    chk("t1 done seen", ok, 1'b1);
    check_stream("t1", p0, 5);
    if (got_cyc.size() >= p0 + 5) begin
      chk("t1 consecutive", got_cyc[p0 + 4] - got_cyc[p0], 4);
      chk("t1 done after last", done_at - got_cyc[p0 + 4], 1);
    end
    after_done("t1");

    // count=0: no pulses, quick done
    load(0, 0);
    p0 = got_pid.size();
    pulse_start(sc);
    wait_done(50, 1'b0, 0, p0, -1, done_at, ok);
    chk("t2 done seen", ok, 1'b1);
    span = done_at - sc;
    chk("t2 done latency 3..6", (span >= 3 && span <= 6), 1'b1);
    chk("t2 no rd_valid", got_pid.size() - p0, 0);
    after_done("t2");

    // count=3 with a 2-cycle write burst during streaming
    load(3, 3);
    p0 = got_pid.size();
    pulse_start(sc);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (mif.mem_rden && mif.mem_address == AW'(1)) begin found = 1'b1; break; end
      @(negedge clk);
    end
    chk("t3 stream started", found, 1'b1);
    i_wr_valid = 1'b1; i_wr_addr = AW'(100); i_wr_data = rnd_word();
    ref_mem[100] = i_wr_data;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("t3 wr_ready", o_wr_ready, 1'b1);
      chk("t3 wren", mif.mem_wren, 1'b1);
      chk("t3 rden held off", mif.mem_rden, 1'b0);
    end
    chk("t3 write addr", mif.mem_address, 100);
    i_wr_valid = 1'b0;
    wait_done(100, 1'b0, 3, p0, -1, done_at, ok);
    chk("t3 done seen", ok, 1'b1);
    check_stream("t3", p0, 3);
    after_done("t3");

    // count word 250 clamps to PN-1 and sets the sticky error
    load(250, PN - 1);
    err_exp = 1'b1;
    p0 = got_pid.size();
    pulse_start(sc);
    wait_done(600, 1'b0, PN - 1, p0, -1, done_at, ok);
    chk("t4 done seen", ok, 1'b1);
    check_stream("t4", p0, PN - 1);
    after_done("t4");
    repeat (3) @(negedge clk);
    chk("t4 cnt_err sticky", o_cnt_err, err_exp);

    // reset mid-stream at pid 2 of 10, then re-sweep
    load(10, 10);
    p0 = got_pid.size();
    pulse_start(sc);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (o_rd_valid && o_rd_pid == AW'(2)) begin found = 1'b1; break; end
      @(negedge clk);
    end
    chk("t5 reached pid 2", found, 1'b1);
    d0 = done_n;
    rst_n = 1'b0;
    err_exp = 1'b0;
    #1;
    chk("t5 async outputs",
        {o_wr_ready, o_rd_valid, o_rd_done, o_busy, o_cnt_err, o_rd_pid, mif.mem_rden,
         mif.mem_wren, mif.mem_address}, '0);
    chk("t5 async data", {o_rd_data, mif.mem_data}, '0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    a0 = got_pid.size();
    repeat (6) @(negedge clk);
    chk("t5 no rd_done", done_n - d0, 0);
    chk("t5 in-flight dropped", got_pid.size() - a0, 0);
    p0 = got_pid.size();
    pulse_start(sc);
    wait_done(100, 1'b0, 10, p0, -1, done_at, ok);
    chk("t5 done seen", ok, 1'b1);
    check_stream("t5", p0, 10);
    after_done("t5");

    // second rd_start while busy is ignored
    load(4, 4);
    p0 = got_pid.size(); d0 = done_n; a0 = addr0_n;
    pulse_start(sc);
    wait_done(100, 1'b0, 4, p0, 3, done_at, ok);
    chk("t6 done seen", ok, 1'b1);
    repeat (10) @(negedge clk);
    chk("t6 single done", done_n - d0, 1);
    chk("t6 single addr0 read", addr0_n - a0, 1);
    check_stream("t6", p0, 4);
    chk("t6 idle", o_busy, 1'b0);

    // random counts with random write traffic outside the swept range
    for (int s = 0; s < 5; s++) begin
      cw = $urandom_range(40, 1);
      load(cw, cw);
      p0 = got_pid.size();
      pulse_start(sc);
      wait_done(400, 1'b1, cw, p0, -1, done_at, ok);
      chk("rnd done seen", ok, 1'b1);
      check_stream("rnd", p0, cw);
      after_done("rnd");
    end

    chk("no rden/wren overlap", conflict_n, 0);
    chk("final cnt_err", o_cnt_err, err_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
